// File: rtl/tick_gen.sv
//------------------------------------------------------------------------------
// Module  : tick_gen
// Brief   : Tick prescaler with run/pause, single-step and a 16-bit tick counter.
//           Define TICK_FAST_SIM_EN to use SIM_DIV as the divide ratio.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_gen #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int SIM_DIV = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        step,
  output logic        tick,
  output logic        running,
  output logic [15:0] tick_cnt
);

`ifdef TICK_FAST_SIM_EN
  localparam int c_div = SIM_DIV;
`else
  localparam int c_div = CLK_HZ / TICK_HZ;
`endif
  localparam int c_cnt_w = (c_div < 2) ? 1 : $clog2(c_div);
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(c_div - 1);
  localparam bit c_cfg_bad = (c_div < 2) || (TICK_HZ < 1) ||
                             (CLK_HZ % TICK_HZ != 0) || (SIM_DIV < 1);

  if (c_cfg_bad) begin : g_cfg_err
    $error("tick_gen: divide ratio must be >= 2 and CLK_HZ a multiple of TICK_HZ");
  end

  typedef enum logic [0:0] {
    ST_PAUSE = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t               r_state;
  logic [c_cnt_w-1:0]   r_div_cnt;
  logic                 r_tick;
  logic                 r_running;
  logic [15:0]          r_tick_cnt;
  logic                 r_run_s1, r_run_s;
  logic                 r_step_s1, r_step_s, r_step_d;
  logic                 w_step_edge;

  // run and step are asynchronous levels; step gets an extra flop for edge detect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_run_s1  <= 1'b0;
      r_run_s   <= 1'b0;
      r_step_s1 <= 1'b0;
      r_step_s  <= 1'b0;
      r_step_d  <= 1'b0;
    end else begin
      r_run_s1  <= run;
      r_run_s   <= r_run_s1;
      r_step_s1 <= step;
      r_step_s  <= r_step_s1;
      r_step_d  <= r_step_s;
    end
  end

  assign w_step_edge = r_step_s & ~r_step_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_PAUSE;
      r_div_cnt  <= '0;
      r_tick     <= 1'b0;
      r_running  <= 1'b0;
      r_tick_cnt <= 16'h0000;
    end else begin
      r_tick <= 1'b0;
      case (r_state)
        ST_PAUSE: begin
          // run wins over a coincident step edge
          if (r_run_s) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
          end else if (w_step_edge) begin
            r_tick     <= 1'b1;
            r_div_cnt  <= '0;
            r_tick_cnt <= r_tick_cnt + 16'd1;
          end
        end
        ST_RUN: begin
          // div_cnt is held on pause so a resume finishes the partial period
          if (!r_run_s) begin
            r_state   <= ST_PAUSE;
            r_running <= 1'b0;
          end else if (r_div_cnt == c_div_last) begin
            r_div_cnt  <= '0;
            r_tick     <= 1'b1;
            r_tick_cnt <= r_tick_cnt + 16'd1;
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: begin
          r_state   <= ST_PAUSE;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign tick     = r_tick;
  assign running  = r_running;
  assign tick_cnt = r_tick_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tick_gen.sv
//------------------------------------------------------------------------------
// Module  : tb_tick_gen
// Brief   : Self-checking bench for tick_gen (divide ratio 10 in either build).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tick_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        step = 1'b0;
  logic        tick;
  logic        running;
  logic [15:0] tick_cnt;
  int          checks = 0;
  int          errors = 0;

  tick_gen #(.CLK_HZ(10), .TICK_HZ(1), .SIM_DIV(10)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .tick(tick), .running(running), .tick_cnt(tick_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: inputs seen two edges late, step edge from input history
  logic        m_tick, m_running, m_in_run;
  logic [15:0] m_cnt;
  int          m_phase;
  logic        pr1, pr2, ps1, ps2, ps3, m_rs, m_se;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      {pr1, pr2, ps1, ps2, ps3} = '0;
      m_tick = 1'b0; m_running = 1'b0; m_in_run = 1'b0;
      m_cnt = 16'h0000; m_phase = 0;
    end else begin
      m_rs = pr2;
      m_se = ps2 & ~ps3;
      m_tick = 1'b0;
      if (!m_in_run) begin
        if (m_rs) begin
          m_in_run = 1'b1; m_running = 1'b1;
        end else if (m_se) begin
          m_tick = 1'b1; m_phase = 0; m_cnt = m_cnt + 16'd1;
        end
      end else begin
        if (!m_rs) begin
          m_in_run = 1'b0; m_running = 1'b0;
        end else if (m_phase == 9) begin
          m_tick = 1'b1; m_phase = 0; m_cnt = m_cnt + 16'd1;
        end else begin
          m_phase = m_phase + 1;
        end
      end
      pr2 = pr1; pr1 = run;
      ps3 = ps2; ps2 = ps1; ps1 = step;
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; run = 1'b0; step = 1'b0;
    #1;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b exp 0", running); end
    checks++; if (tick_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt got %h exp 0000", tick_cnt); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_free_run();
    do_reset();
    run = 1'b1;
    for (int k = 1; k <= 33; k++) begin
      cyc();
      checks++;
      if (running !== (k >= 3)) begin errors++; $display("FAIL free_run_running edge %0d got %b exp %b", k, running, k >= 3); end
      checks++;
      if (tick !== (k == 13 || k == 23 || k == 33)) begin errors++; $display("FAIL free_run_tick edge %0d got %b", k, tick); end
    end
    checks++; if (tick_cnt !== 16'd3) begin errors++; $display("FAIL free_run_cnt got %0d exp 3", tick_cnt); end
  endtask

  // Continues from test_free_run: two more counting edges, then run drops
  task automatic test_pause_resume();
    repeat (2) begin
      cyc();
      checks++; if (tick !== 1'b0) begin errors++; $display("FAIL pause_pre_tick got %b exp 0", tick); end
    end
    for (int k = 1; k <= 30; k++) begin
      run = (k >= 21);
      cyc();
      checks++;
      if (running !== (k <= 2 || k >= 23)) begin errors++; $display("FAIL pause_running k %0d got %b", k, running); end
      checks++;
      if (tick !== (k == 29)) begin errors++; $display("FAIL pause_tick k %0d got %b exp %b", k, tick, k == 29); end
    end
    checks++; if (tick_cnt !== 16'd4) begin errors++; $display("FAIL pause_cnt got %0d exp 4", tick_cnt); end
  endtask

  task automatic test_single_step();
    do_reset();
    for (int p = 0; p < 3; p++) begin
      for (int k = 1; k <= 10; k++) begin
        step = (k <= 4);
        cyc();
        checks++;
        if (tick !== (k == 3)) begin errors++; $display("FAIL step_tick press %0d k %0d got %b", p, k, tick); end
      end
    end
    for (int k = 1; k <= 56; k++) begin
      step = (k <= 50);
      cyc();
      checks++;
      if (tick !== (k == 3)) begin errors++; $display("FAIL step_hold_tick k %0d got %b", k, tick); end
    end
    checks++; if (tick_cnt !== 16'd4) begin errors++; $display("FAIL step_cnt got %0d exp 4", tick_cnt); end
    for (int k = 1; k <= 15; k++) begin
      run = 1'b1;
      step = (k >= 5 && k <= 7);
      cyc();
      checks++;
      if (tick !== (k == 13)) begin errors++; $display("FAIL step_in_run_tick k %0d got %b", k, tick); end
      checks++;
      if (running !== (k >= 3)) begin errors++; $display("FAIL step_in_run_running k %0d got %b", k, running); end
    end
    step = 1'b0;
    checks++; if (tick_cnt !== 16'd5) begin errors++; $display("FAIL step_run_cnt got %0d exp 5", tick_cnt); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      run = 1'b1; step = 1'b1;
      cyc();
      checks++;
      if (running !== (k >= 3)) begin errors++; $display("FAIL simul_running k %0d got %b", k, running); end
      checks++;
      if (tick !== (k == 13)) begin errors++; $display("FAIL simul_tick k %0d got %b exp %b", k, tick, k == 13); end
    end
    step = 1'b0;
    checks++; if (tick_cnt !== 16'd1) begin errors++; $display("FAIL simul_cnt got %0d exp 1", tick_cnt); end
  endtask

  task automatic test_wrap();
    int n;
    n = 0;
    force dut.r_tick_cnt = 16'hFFFE;
    #1;
    release dut.r_tick_cnt;
    for (int k = 0; k < 25 && n < 2; k++) begin
      cyc();
      if (tick === 1'b1) begin
        n++;
        checks++;
        if (n == 1 && tick_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_first got %h exp FFFF", tick_cnt); end
        if (n == 2 && tick_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_second got %h exp 0000", tick_cnt); end
      end
    end
    checks++; if (n != 2) begin errors++; $display("FAIL wrap_ticks got %0d exp 2", n); end
  endtask

  task automatic test_async_reset();
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      cyc();
      if (tick === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL areset_find_tick got 0 exp 1"); end
    rst = 1'b1; run = 1'b0;
    #1;
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL areset_tick got %b exp 0", tick); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL areset_running got %b exp 0", running); end
    checks++; if (tick_cnt !== 16'h0000) begin errors++; $display("FAIL areset_cnt got %h exp 0000", tick_cnt); end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      cyc();
      checks++;
      if (running !== 1'b0 || tick !== 1'b0) begin errors++; $display("FAIL areset_pause k %0d got running %b tick %b exp 0 0", k, running, tick); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 39) == 0) run = ~run;
      if ($urandom_range(0, 5) == 0) step = ~step;
      cyc();
      checks++; if (tick !== m_tick) begin errors++; $display("FAIL rand_tick cyc %0d got %b exp %b", c, tick, m_tick); end
      checks++; if (running !== m_running) begin errors++; $display("FAIL rand_running cyc %0d got %b exp %b", c, running, m_running); end
      checks++; if (tick_cnt !== m_cnt) begin errors++; $display("FAIL rand_cnt cyc %0d got %0d exp %0d", c, tick_cnt, m_cnt); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_free_run();
    test_pause_resume();
    test_single_step();
    test_simultaneous();
    test_wrap();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tick_gen.md
# tick_gen

- Tick prescaler that sits directly upstream of the traffic light controller. It divides the system clock into a 1-cycle-wide `tick` pulse, 1 Hz by default.
- Adds run/pause control and a single-step pushbutton for bring-up, plus a free-running tick counter for debug.
- `tick` connects straight to the controller's `tick` input; both blocks share `clk`.

## Interface

Parameters:
- `CLK_HZ`, default 50_000_000: system clock frequency.
- `TICK_HZ`, default 1: tick rate. `CLK_HZ` must be an integer multiple of `TICK_HZ`.
- `SIM_DIV`, default 10: divide ratio used only when `TICK_FAST_SIM_EN` is defined.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `run` in 1: asynchronous level. 1 = free-run, 0 = pause.
- `step` in 1: asynchronous pushbutton level. A rising edge while paused emits one tick.
- `tick` out 1: registered, exactly one `clk` cycle wide.
- `running` out 1: registered, 1 when the FSM is in RUN.
- `tick_cnt` out 16: count of ticks emitted, wraps.

## Operation

- `DIV` = `CLK_HZ/TICK_HZ`, or `SIM_DIV` under the macro. `DIV` ≥ 2, checked at elaboration.
- Divider counter `div_cnt` is `$clog2(DIV)` bits and counts 0..`DIV-1`.
- `run` and `step` each pass through a 2-flop synchronizer, giving `run_s` and `step_s`.
- A third flop on `step_s` gives `step_d`. `step_edge` = `step_s & ~step_d`.
- FSM states:
  - **PAUSE** (reset state). `div_cnt` holds. If `run_s` = 1, go to RUN. Else if `step_edge` = 1: `tick`<=1, `div_cnt`<=0, stay in PAUSE.
  - **RUN**. If `run_s` = 0, go to PAUSE: `div_cnt` holds its value and `tick`<=0 on that edge. Otherwise, if `div_cnt` == `DIV-1`: `div_cnt`<=0 and `tick`<=1; else `div_cnt`<=`div_cnt`+1 and `tick`<=0.
- `step_edge` is ignored in RUN.
- `tick` is 0 on every edge not listed above.
- `running`<=1 on the edge that enters RUN; `running`<=0 on the edge that enters PAUSE.
- `tick_cnt`<=`tick_cnt`+1 (mod 2^16) on every edge that sets `tick`<=1. 16'hFFFF wraps to 16'h0000.
- Resume from pause continues from the held `div_cnt`. A partial period is not restarted.
- Single-step clears `div_cnt`, so a later RUN starts a full `DIV` period.

## Timing

- Reset values, applied asynchronously on `rst` assertion: state=PAUSE, `tick`=0, `running`=0, `tick_cnt`=0, `div_cnt`=0, all synchronizer flops 0.
- Reset mid-pulse truncates `tick` immediately.
- `rst` deassertion is assumed synchronous to `clk` at system level.
- Edges are counted after `rst` deasserts.
- With `run` held 1: `run_s`=1 after edge 2, RUN entered on edge 3.
- First `tick` is set on edge 3+`DIV`, then every `DIV` edges.
- `run` falling: 2 sync edges, then PAUSE on edge 3. A tick can still be emitted on edges 1–2.
- `step` rising: `step_s`=1 after edge 2, `step_edge` true in the following cycle, tick set on edge 3.
- Holding `step` high gives exactly one tick; a new tick needs a release and a fresh press.
- Simultaneous `run_s` rise and `step_edge` in PAUSE: RUN wins, the step is dropped, no extra tick.
- Tick period in RUN is exactly `DIV` cycles, with no jitter.

## Configuration

- `TICK_FAST_SIM_EN`:
  - Defined: `DIV` = `SIM_DIV`, so simulation runs `SIM_DIV` cycles per tick.
  - Undefined: `DIV` = `CLK_HZ/TICK_HZ`, and `SIM_DIV` is unused.
- All other behaviour is identical in both builds.

## Test plan

All scenarios use the `TICK_FAST_SIM_EN` build with `SIM_DIV`=10.

- Reset, then `run`=1 held: `running`=1 after edge 3. `tick` pulses 1 cycle after edges 13, 23, 33. `tick_cnt`=3 after edge 33.
- Pause and resume: `run` drops with `div_cnt`=4, then returns 20 cycles later. No tick while paused. First tick after resume follows 6 more counting edges in RUN.
- Single-step: while paused, three separated `step` presses give exactly 3 one-cycle ticks, each 3 edges after its press. Holding `step` high for 50 cycles gives 1 tick. A press while in RUN adds no tick.
- Simultaneous: `run` and `step` rise in the same cycle from PAUSE. Result is RUN with no extra tick; the next tick is 10 edges after RUN entry.
- Wrap: free-run for 65 536 ticks (force `tick_cnt`=16'hFFFE to shorten). `tick_cnt` reads FFFF, then 0000.
- Async reset mid-pulse: assert `rst` while `tick`=1. `tick`, `running`, `tick_cnt` are 0 before the next `clk` edge, and the FSM is in PAUSE.
